// File: rtl/simple_module_seq.sv
// Command sequencer: queues (op, A, B) requests and time-shares one simple_module datapath.
// Optional SEQ_OPCOUNT_EN adds a 16-bit response handshake counter (op_count).
module simple_module_seq #(
  parameter int FIFO_DEPTH = 4,
  parameter int LATENCY    = 2,
  parameter int OP_W       = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OP_W-1:0] cmd_op,
  input  logic [7:0]      cmd_a,
  input  logic [7:0]      cmd_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [7:0]      rsp_data,
  output logic [7:0]      dp_a,
  output logic [7:0]      dp_b,
  output logic [7:0]      dp_ctrl,
  input  logic [7:0]      dp_q,
  output logic            busy
`ifdef SEQ_OPCOUNT_EN
  ,
  output logic [15:0]     op_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] CTRL_IDLE = 8'hC0;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [7:0]      a;
    logic [7:0]      b;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  cmd_t            r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_cnt;
  state_t          r_state, w_next;
  logic [3:0]      r_lat;
  logic [7:0]      r_dp_a, r_dp_b, r_dp_ctrl, r_rsp_data;
  logic            r_rsp_valid;

  logic            w_full, w_empty, w_push, w_pop, w_issue;
  cmd_t            w_head;

  assign w_full  = (r_cnt == CW'(FIFO_DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_push  = cmd_valid && !w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty;
  assign w_head  = r_mem[r_rptr];
  // NOP entries are popped and dropped without touching the datapath
  assign w_issue = w_pop && (w_head.op != '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_issue)         w_next = S_WAIT;
      S_WAIT:  if (r_lat == 4'd0)   w_next = S_HOLD;
      S_HOLD:  if (rsp_ready)       w_next = S_IDLE;
      default:                      w_next = S_IDLE;
    endcase
  end

  // Datapath drive and response capture; A/B are left at the last op after completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_a      <= '0;
      r_dp_b      <= '0;
      r_dp_ctrl   <= CTRL_IDLE;
      r_lat       <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_issue) begin
          r_dp_a    <= w_head.a;
          r_dp_b    <= w_head.b;
          r_dp_ctrl <= CTRL_IDLE | 8'(w_head.op);
          r_lat     <= 4'(LATENCY - 1);
        end
        S_WAIT: if (r_lat == 4'd0) begin
          r_rsp_data  <= dp_q;
          r_rsp_valid <= 1'b1;
          r_dp_ctrl   <= CTRL_IDLE;
        end else begin
          r_lat <= r_lat - 4'd1;
        end
        S_HOLD: if (rsp_ready) r_rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef SEQ_OPCOUNT_EN
  logic [15:0] r_op_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_op_cnt <= '0;
    else if (r_rsp_valid && rsp_ready) r_op_cnt <= r_op_cnt + 16'd1;
  end
  assign op_count = r_op_cnt;
`endif

  assign cmd_ready = !w_full;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign dp_a      = r_dp_a;
  assign dp_b      = r_dp_b;
  assign dp_ctrl   = r_dp_ctrl;
  assign busy      = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_simple_module_seq.sv
// Randomized + directed bench for simple_module_seq against a queue-based response model.
module tb_simple_module_seq;
  localparam int OP_W = 4;

  logic            clk, rst_n;
  logic            cmd_valid, cmd_ready;
  logic [OP_W-1:0] cmd_op;
  logic [7:0]      cmd_a, cmd_b;
  logic            rsp_valid, rsp_ready;
  logic [7:0]      rsp_data, dp_a, dp_b, dp_ctrl, dp_q;
  logic            busy;
`ifdef SEQ_OPCOUNT_EN
  logic [15:0]     op_count;
`endif

  simple_module_seq #(.FIFO_DEPTH(4), .LATENCY(2), .OP_W(OP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .dp_a(dp_a), .dp_b(dp_b), .dp_ctrl(dp_ctrl), .dp_q(dp_q),
    .busy(busy)
`ifdef SEQ_OPCOUNT_EN
    , .op_count(op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_q(input logic [OP_W-1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      1:       return a + b;
      2:       return a - b;
      default: return a ^ b;
    endcase
  endfunction

  // Datapath stand-in: one register stage, well inside the 2-edge budget
  always @(posedge clk) dp_q <= ref_q(dp_ctrl[OP_W-1:0], dp_a, dp_b);

  int n_chk = 0, n_pass = 0;
  int n_rsp = 0, hs_since_rst = 0;
  logic [7:0] last_d;
  logic [7:0] expq[$];
  bit rnd_rdy = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Monitor: inputs change #1 after posedge, so negedge values are what the next edge sees
  bit prev_v = 0, prev_hs = 0;
  logic [7:0] prev_d;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 0;
    end else begin
      if (prev_v && !prev_hs) begin
        chk("hold_valid", 32'(rsp_valid), 1);
        chk("hold_data", 32'(rsp_data), 32'(prev_d));
      end
      if (rsp_valid && rsp_ready) begin
        if (expq.size() == 0) chk("rsp_unexpected", 32'(expq.size()), 1);
        else chk("rsp_data", 32'(rsp_data), 32'(expq.pop_front()));
        n_rsp++;
        hs_since_rst++;
        last_d = rsp_data;
      end
      if (cmd_valid && cmd_ready && cmd_op != 0) expq.push_back(ref_q(cmd_op, cmd_a, cmd_b));
      prev_v  = rsp_valid;
      prev_hs = rsp_valid && rsp_ready;
      prev_d  = rsp_data;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
    if (rnd_rdy) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [OP_W-1:0] op, input logic [7:0] a, input logic [7:0] b);
    bit ok, acc;
    cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      acc = cmd_ready;
      cyc();
      ok = acc;
    end
    if (!ok) chk("send_timeout", 32'(ok), 1);
    cmd_valid = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500 && (busy || rsp_valid); i++) cyc();
    chk("idle_timeout", 32'(busy || rsp_valid), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d0, a0, b0;
    int n0;
    rst_n = 0; cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; rsp_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dp_ctrl", 32'(dp_ctrl), 32'hC0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_dp_a", 32'(dp_a), 0);
`ifdef SEQ_OPCOUNT_EN
    chk("rst_op_count", 32'(op_count), 0);
`endif
    rst_n = 1;
    cyc();

    // Latency: push at N, drive after N+1, response after N+3
    cmd_valid = 1; cmd_op = 1; cmd_a = 10; cmd_b = 0;
    cyc(); cmd_valid = 0;
    chk("lat_busy", 32'(busy), 1);
    cyc();
    chk("lat_dp_ctrl", 32'(dp_ctrl), 32'hC1);
    chk("lat_dp_a", 32'(dp_a), 10);
    chk("lat_dp_b", 32'(dp_b), 0);
    cyc();
    chk("lat_early_valid", 32'(rsp_valid), 0);
    cyc();
    chk("lat_rsp_valid", 32'(rsp_valid), 1);
    chk("lat_rsp_data", 32'(rsp_data), 10);
    chk("lat_ctrl_idle", 32'(dp_ctrl), 32'hC0);
    wait_idle();

    // Back-pressure: one op parks in HOLD, four more fill the FIFO
    n0 = n_rsp;
    rsp_ready = 0;
    for (int i = 0; i < 5; i++)
      send(OP_W'($urandom_range(1, 2)), 8'($urandom), 8'($urandom));
    chk("full_ready", 32'(cmd_ready), 0);
    chk("full_busy", 32'(busy), 1);
    cmd_valid = 1; cmd_op = 1; cmd_a = 8'h55; cmd_b = 8'h11;
    repeat (3) begin
      chk("full_reject", 32'(cmd_ready), 0);
      cyc();
    end
    cmd_valid = 0;
    d0 = rsp_data; a0 = dp_a; b0 = dp_b;
    repeat (10) cyc();
    chk("stall_valid", 32'(rsp_valid), 1);
    chk("stall_data", 32'(rsp_data), 32'(d0));
    chk("stall_dp_a", 32'(dp_a), 32'(a0));
    chk("stall_dp_b", 32'(dp_b), 32'(b0));
    chk("stall_ctrl", 32'(dp_ctrl), 32'hC0);
    chk("stall_no_pop", 32'(cmd_ready), 0);
    rsp_ready = 1;
    wait_idle();
    chk("drain_count", 32'(n_rsp - n0), 5);

    // NOP is dropped, following op answers alone
    n0 = n_rsp;
    send(0, 8'd7, 8'd7);
    send(2, 8'd9, 8'd4);
    wait_idle();
    chk("nop_count", 32'(n_rsp - n0), 1);
    chk("nop_data", 32'(last_d), 5);

    // Random traffic with random back-pressure
    rnd_rdy = 1;
    for (int i = 0; i < 80; i++) begin
      send(OP_W'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) cyc();
    end
    rsp_ready = 1; rnd_rdy = 0;
    wait_idle();
    chk("rand_drained", 32'(expq.size()), 0);
`ifdef SEQ_OPCOUNT_EN
    chk("op_count", 32'(op_count), 32'(hs_since_rst));
`endif

    // Reset in WAIT: everything dropped immediately
    send(1, 8'd3, 8'd4);
    cyc();
    chk("mid_in_wait", 32'(dp_ctrl), 32'hC1);
    #2 rst_n = 0;
    expq.delete();
    hs_since_rst = 0;
    #1;
    chk("mid_rst_ctrl", 32'(dp_ctrl), 32'hC0);
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(cmd_ready), 1);
    chk("mid_rst_dp_a", 32'(dp_a), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    repeat (6) cyc();
    chk("post_rst_valid", 32'(rsp_valid), 0);
    chk("post_rst_busy", 32'(busy), 0);
`ifdef SEQ_OPCOUNT_EN
    chk("post_rst_op_count", 32'(op_count), 0);
`endif
    chk("final_queue", 32'(expq.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
